weight_pingpong_loader: RTL

WEIGHT_PINGPONG_LOADER -- requirements
Module: weight_pingpong_loader

---
 rtl/cnn_param_pkg.sv | 18 +
 rtl/weight_bank_ram.sv | 31 +++
 rtl/weight_pingpong_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cnn_param_pkg.sv
// Shared CNN weight-path parameters, loader FSM encoding and a small
// rounding helper used when sizing a layer into kernel groups.
package cnn_param_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int KERNEL_SIZE_MAX = 3;
    localparam int PARA_KERNEL     = 2;
    localparam int DEPTH_MAX       = 512;

    typedef enum logic [1:0] {IDLE, REQ, LOAD, WAIT_FREE} state_e;

    function automatic logic [15:0] ceil_div(input logic [15:0] n, input int unsigned d);
        logic [16:0] sum;
        sum = {1'b0, n} + 17'(d - 1);
        return 16'(sum / 17'(d));
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// Simple dual-port weight RAM: one write port, one registered read port
// with one cycle of read latency. Storage itself is never reset.
module weight_bank_ram #(
    parameter int  WIDTH = 288,
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_q <= '0;
        else       rd_data_q <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/weight_pingpong_loader.sv
// Weight loader: requests kernel groups into a weight bank and hands full banks
// to compute. WEIGHT_PINGPONG_EN selects two banks (load overlaps compute).
module weight_pingpong_loader #(
    parameter int  DATA_WIDTH      = cnn_param_pkg::DATA_WIDTH,
    parameter int  KERNEL_SIZE_MAX = cnn_param_pkg::KERNEL_SIZE_MAX,
    parameter int  PARA_KERNEL     = cnn_param_pkg::PARA_KERNEL,
    parameter int  DEPTH_MAX       = cnn_param_pkg::DEPTH_MAX,
    localparam int AW              = $clog2(2 * DEPTH_MAX),
    localparam int SLICE_W         = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * PARA_KERNEL * DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [AW-1:0]      cfg_depth,
    input  logic [15:0]        cfg_kernel_num,
    input  logic               wr_valid,
    input  logic [AW-1:0]      wr_addr,
    input  logic [SLICE_W-1:0] wr_data,
    input  logic               wr_last,
    output logic               req_valid,
    output logic [AW-1:0]      req_base,
    output logic               cmp_bank_valid,
    output logic               cmp_bank,
    input  logic [AW-1:0]      cmp_rd_addr,
    output logic [SLICE_W-1:0] cmp_rd_data,
    input  logic               cmp_done,
    output logic               layer_done,
    output logic               err_addr
);
    import cnn_param_pkg::*;

`ifdef WEIGHT_PINGPONG_EN
    localparam bit PINGPONG = 1'b1;
`else
    localparam bit PINGPONG = 1'b0;
`endif
    localparam int            NB         = PINGPONG ? 2 : 1;
    localparam int            RAW        = $clog2(NB * DEPTH_MAX);
    localparam logic [AW-1:0] BANK1_BASE = AW'(DEPTH_MAX);

    state_e        state_q;
    logic          wr_bank_q, rd_bank_q;
    logic [1:0]    full_q, full_d;
    logic [AW-1:0] depth_q, base_q, rd_abs;
    logic [15:0]   groups_q, greq_q, gdone_q;
    logic          req_valid_q, layer_done_q, err_q;
    logic          in_load, addr_ok, wr_en, last_acc, done_acc;
    logic [AW:0]   win_lo, win_hi;

    always_comb begin
        in_load  = (state_q == LOAD);
        win_lo   = {1'b0, base_q};
        win_hi   = win_lo + {1'b0, depth_q};
        addr_ok  = ({1'b0, wr_addr} >= win_lo) && ({1'b0, wr_addr} < win_hi);
        wr_en    = in_load && wr_valid && addr_ok;
        last_acc = in_load && wr_last;
        done_acc = cmp_done && full_q[rd_bank_q];
        // Release before fill: both may hit in one cycle, always on different banks.
        full_d = full_q;
        if (done_acc) full_d[rd_bank_q] = 1'b0;
        if (last_acc) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= '0;
            depth_q      <= '0;
            base_q       <= '0;
            groups_q     <= '0;
            greq_q       <= '0;
            gdone_q      <= '0;
            req_valid_q  <= 1'b0;
            layer_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            layer_done_q <= 1'b0;
            full_q       <= full_d;
            if (in_load && wr_valid && !addr_ok) err_q <= 1'b1;
            if (done_acc) begin
                rd_bank_q <= PINGPONG ? ~rd_bank_q : 1'b0;
                gdone_q   <= gdone_q + 16'd1;
            end
            unique case (state_q)
                IDLE: if (cfg_start) begin
                    depth_q   <= cfg_depth;
                    groups_q  <= ceil_div(cfg_kernel_num, PARA_KERNEL);
                    greq_q    <= '0;
                    gdone_q   <= '0;
                    wr_bank_q <= 1'b0;
                    rd_bank_q <= 1'b0;
                    full_q    <= '0;
                    if (cfg_kernel_num == 16'd0) layer_done_q <= 1'b1;
                    else                         state_q      <= REQ;
                end
                REQ: if (greq_q < groups_q) begin
                    if (!full_q[wr_bank_q]) begin
                        state_q     <= LOAD;
                        req_valid_q <= 1'b1;
                        base_q      <= wr_bank_q ? BANK1_BASE : '0;
                    end else begin
                        state_q <= WAIT_FREE;
                    end
                end
                LOAD: if (wr_last) begin
                    req_valid_q <= 1'b0;
                    greq_q      <= greq_q + 16'd1;
                    wr_bank_q   <= PINGPONG ? ~wr_bank_q : 1'b0;
                    state_q     <= REQ;
                end
                WAIT_FREE: if (!full_d[wr_bank_q]) state_q <= REQ;
                default: state_q <= IDLE;
            endcase
            if (done_acc && (16'(gdone_q + 16'd1) == groups_q)) begin
                layer_done_q <= 1'b1;
                req_valid_q  <= 1'b0;
                state_q      <= IDLE;
            end
        end
    end

    // Compute reads are bank-relative; the bank is sampled alongside the address.
    assign rd_abs = (rd_bank_q ? BANK1_BASE : '0) + cmp_rd_addr;

    weight_bank_ram #(
        .WIDTH (SLICE_W),
        .DEPTH (NB * DEPTH_MAX)
    ) u_ram (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (RAW'(wr_addr)),
        .wr_data_i (wr_data),
        .rd_addr_i (RAW'(rd_abs)),
        .rd_data_o (cmp_rd_data)
    );

    assign req_valid      = req_valid_q;
    assign req_base       = base_q;
    assign cmp_bank_valid = full_q[rd_bank_q];
    assign cmp_bank       = rd_bank_q;
    assign layer_done     = layer_done_q;
    assign err_addr       = err_q;

endmodule
